ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset).
- It is the transmit counterpart of the keyboard receive controller and shares the same PS2_CLK/PS2_DAT pins.
- It drives the pins open-drain. The top level ties each pin to 1'bz unless the matching *_oe is high, in which case the pin is driven to 0.
- It runs on the single 50 MHz system clock and samples the device-generated PS/2 clock.

Parameters:
- INHIBIT_CYCLES, 6000: system cycles the host holds the clock low before the start bit (120 us at 50 MHz).
- FIRST_EDGE_TIMEOUT, 750000: maximum cycles from clock release to the first device falling edge (15 ms).
- BIT_TIMEOUT, 100000: maximum cycles between consecutive device falling edges (2 ms).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high when a new byte can be accepted.
- ps2_clk_in  in  1  raw PS2_CLK pin level (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pin level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.
- tx_done  out  1  one-cycle pulse when a frame completes.
- tx_ack  out  1  ACK bit result, qualified by tx_done; 1 = device acknowledged.
- tx_error  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset is asynchronous, active-low, one clock domain (CLOCK_50).
- Reset values: state IDLE; ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1, tx_done=0, tx_ack=0, tx_error=0; all counters 0.
- Reset asserted mid-frame: both lines are released immediately, with no partial-frame completion and no done or error pulse.
- Input sync: each raw pin passes through a 2-flop synchronizer.
- Falling edge detect: a third register holds the previous synced clock; fall = prev & ~cur. Latency from pin edge to fall is 3 cycles.
- Handshake: a byte is accepted on tx_valid & tx_ready. tx_data is latched in that cycle.
  - The block computes odd parity: the parity bit is 1 when tx_data contains an even number of 1s.
  - tx_ready falls on the next cycle and stays low until the frame completes or aborts.
  - tx_valid while tx_ready=0 is ignored.
- State machine:
  - IDLE: tx_ready=1. On accept, go to INHIBIT and clear the cycle counter.
  - INHIBIT: ps2_clk_oe=1. For the last cycle (count == INHIBIT_CYCLES-1) also assert ps2_dat_oe=1 (start bit), then go to REQ.
  - REQ: ps2_clk_oe=0, ps2_dat_oe=1. Wait for fall.
    - On fall, drive data bit0 (ps2_dat_oe = ~bit), set bit index 1, go to XFER.
    - If count reaches FIRST_EDGE_TIMEOUT, go to ABORT.
  - XFER: on each fall:
    - index 1..7: drive data bit[index].
    - index 8: drive the parity bit.
    - index 9: release data (stop bit, ps2_dat_oe=0).
    - index 10: sample synced data; tx_ack = ~dat_sync. Go to FINISH.
    - The counter clears on every fall. If count reaches BIT_TIMEOUT, go to ABORT.
  - FINISH: both oe=0. Wait until synced clock=1 and synced data=1 (device released), then pulse tx_done for one cycle and return to IDLE.
    - If BIT_TIMEOUT expires here, pulse tx_done with the sampled tx_ack anyway and return to IDLE.
  - ABORT: one cycle. Both oe=0, pulse tx_error, go to IDLE. tx_ack holds its previous value.
- Counters are 20 bits wide; the maximum value 750000 fits in 20 bits.
- Simultaneous events: a fall in the same cycle the timeout count is reached is treated as a valid edge (edge wins).
- ps2_clk_oe and ps2_dat_oe are registered outputs and change only on the CLOCK_50 rising edge.
- A device clock edge arriving during INHIBIT is ignored; the host owns the clock in that state.

Test Plan:
- Reset idle: reset_n=0 then 1 -> tx_ready=1, both oe=0; tx_done and tx_error stay 0 with no stimulus.
- Send 0xED with a device model clocking at 80 us period and driving ACK low:
  - ps2_clk_oe is high for exactly 6000 cycles; ps2_dat_oe rises on the last inhibit cycle.
  - The model captures data 1,0,1,1,0,1,1,1 (LSB first), then parity 1, then stop 1.
  - tx_done pulses once with tx_ack=1 after both lines return high.
- Send 0xF4 with the device omitting ACK (data left high on the 11th edge) -> parity bit captured is 0; tx_done pulses with tx_ack=0.
- No device (clock never toggles after release) -> tx_error pulses 750000 cycles after entering REQ, both oe=0, tx_ready=1, no tx_done.
- Device stops after 4 edges -> tx_error pulses 100000 cycles after the 4th fall.
- Reset mid-XFER after 5 edges -> both oe go to 0 asynchronously, no pulses.
- tx_valid held high during a frame -> exactly one frame is sent per accept; a second frame starts only on the cycle after tx_ready returns high.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter.
//
// This block sends one command byte to a PS/2 device, for example 0xED
// (set LEDs), 0xF4 (enable) or 0xFF (reset). It shares the PS2_CLK and
// PS2_DAT pins with the keyboard receiver. Both pins are open-drain: the
// top level pulls a pin low while its *_oe output is high and otherwise
// leaves it at 1'bz.
//
// Frame sequence:
//   1. The host holds the clock low (inhibit).
//   2. On the last inhibit cycle the host also pulls data low (start bit).
//   3. The host releases the clock and waits for device clock edges.
//   4. On each falling edge of the device clock the host presents the next
//      bit: data[0..7], then odd parity, then the stop bit (line released).
//   5. On the 11th falling edge the host samples the device's ACK.
//
// Ports:
//   CLOCK_50    in   system clock (50 MHz)
//   reset_n     in   asynchronous active-low reset
//   tx_data     in   [7:0] command byte, latched on accept
//   tx_valid    in   request to send tx_data
//   tx_ready    out  high when a new byte can be accepted
//   ps2_clk_in  in   raw PS2_CLK pin level (asynchronous)
//   ps2_dat_in  in   raw PS2_DAT pin level (asynchronous)
//   ps2_clk_oe  out  1 = pull PS2_CLK low
//   ps2_dat_oe  out  1 = pull PS2_DAT low
//   tx_done     out  one-cycle pulse when a frame completes
//   tx_ack      out  ACK result, qualified by tx_done (1 = acknowledged)
//   tx_error    out  one-cycle pulse when a timeout aborts the frame
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES     = 6000,
  parameter int unsigned FIRST_EDGE_TIMEOUT = 750000,
  parameter int unsigned BIT_TIMEOUT        = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_done,
  output logic       tx_ack,
  output logic       tx_error
);

  localparam int CW = 20;

  // Terminal counts. The counter starts at 0, so a window of N cycles ends
  // when the counter equals N-1.
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_PRE  = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] REQ_LAST = CW'(FIRST_EDGE_TIMEOUT - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_TIMEOUT - 1);

  // With a single-cycle inhibit, the start bit must be set up together with
  // the clock inhibit.
  localparam bit INH_ONE = (INHIBIT_CYCLES == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_XFER,
    S_FINISH,
    S_ABORT
  } state_t;

  // ---------------------------------------------------------------------
  // Pin synchronisers and falling-edge detector
  // ---------------------------------------------------------------------
  // The synchronisers reset to 1 because idle PS/2 lines are pulled high.
  // This avoids a false edge immediately after reset.
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;
  logic fall;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;

  // ---------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      data_q, data_d;
  logic            par_q, par_d;
  logic            clk_oe_q, clk_oe_d;
  logic            dat_oe_q, dat_oe_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      par_q    <= par_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  // The pin enables are computed from the next state, so each registered
  // output already shows its new value during the first cycle of that state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    par_d    = par_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    ack_d    = ack_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_valid && ready_q) begin
          data_d   = tx_data;
          // Odd parity: the parity bit is 1 when the byte has an even
          // number of 1s.
          par_d    = ~^tx_data;
          cnt_d    = '0;
          idx_d    = '0;
          clk_oe_d = 1'b1;
          dat_oe_d = INH_ONE;
          state_d  = S_INHIBIT;
        end
      end

      // The host owns the clock line here, so device edges are ignored.
      S_INHIBIT: begin
        clk_oe_d = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == INH_PRE) begin
          dat_oe_d = 1'b1;
        end
        if (cnt_q == INH_LAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_REQ;
        end
      end

      // The start bit stays on the data line until the device's first
      // falling clock edge.
      S_REQ: begin
        clk_oe_d = 1'b0;
        if (fall) begin
          dat_oe_d = ~data_q[0];
          idx_d    = 4'd1;
          cnt_d    = '0;
          state_d  = S_XFER;
        end else if (cnt_q == REQ_LAST) begin
          dat_oe_d = 1'b0;
          err_d    = 1'b1;
          cnt_d    = '0;
          state_d  = S_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // A falling edge takes priority over a timeout in the same cycle.
      S_XFER: begin
        if (fall) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          if (idx_q <= 4'd7) begin
            dat_oe_d = ~data_q[idx_q[2:0]];
          end else if (idx_q == 4'd8) begin
            dat_oe_d = ~par_q;
          end else if (idx_q == 4'd9) begin
            dat_oe_d = 1'b0;          // stop bit: release data
          end else begin
            ack_d    = ~dat_sync_q;   // device pulls data low to ACK
            dat_oe_d = 1'b0;
            state_d  = S_FINISH;
          end
        end else if (cnt_q == BIT_LAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          err_d    = 1'b1;
          cnt_d    = '0;
          state_d  = S_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Wait for the device to release both lines. A device that never
      // releases them still completes the frame with the ACK already
      // sampled; it does not count as an error.
      S_FINISH: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (clk_sync_q && dat_sync_q) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == BIT_LAST) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_ABORT: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  assign tx_ready   = ready_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_done    = done_q;
  assign tx_ack     = ack_q;
  assign tx_error   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

  // Scaled-down timing so the run stays short.
  localparam int INH = 40;
  localparam int FET = 2000;
  localparam int BT  = 500;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       tx_done, tx_ack, tx_error;

  // Device side of the open-drain lines: 1 = released.
  logic dev_clk, dev_dat;
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES    (INH),
    .FIRST_EDGE_TIMEOUT(FET),
    .BIT_TIMEOUT       (BT)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .tx_done   (tx_done),
    .tx_ack    (tx_ack),
    .tx_error  (tx_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event monitor, sampled on the falling clock edge.
  int   cyc = 0;
  int   done_cnt = 0, err_cnt = 0, oe_rises = 0;
  int   done_cyc = 0, ready_rise_cyc = 0, oe_rise_cyc = 0;
  logic ack_at_done = 1'b0;
  logic ready_prev = 1'b0, clkoe_prev = 1'b0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (tx_done) begin
      done_cnt    <= done_cnt + 1;
      done_cyc    <= cyc;
      ack_at_done <= tx_ack;
    end
    if (tx_error) err_cnt <= err_cnt + 1;
    if (tx_ready && !ready_prev) ready_rise_cyc <= cyc;
    if (ps2_clk_oe && !clkoe_prev) begin
      oe_rise_cyc <= cyc;
      oe_rises    <= oe_rises + 1;
    end
    ready_prev <= tx_ready;
    clkoe_prev <= ps2_clk_oe;
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Device model: clock one frame and capture what the host sends.
  // The expected frame is computed here: LSB-first data, odd parity, stop=1.
  task automatic serve(input logic [7:0] d, input bit give_ack, input bit chk_inh,
                       input int half, input bit keep_valid, input logic [7:0] after_data);
    int n, first_dat, d0, e0, guard, rel_cyc;
    logic [9:0] cap, exp_bits;
    logic exp_par;
    d0 = done_cnt;
    e0 = err_cnt;
    rel_cyc = 0;
    cap = '0;
    exp_par  = ($countones(d) % 2 == 0);
    exp_bits = {1'b1, exp_par, d};
    if (chk_inh) begin
      guard = 0;
      while (!ps2_clk_oe && guard < 20) begin tick(); guard++; end
      check("inhibit_begin", 32'(ps2_clk_oe), 1);
      tx_valid = keep_valid;
      tx_data  = after_data;
      n = 0;
      first_dat = 0;
      while (ps2_clk_oe && n < INH + 20) begin
        n++;
        if (ps2_dat_oe && first_dat == 0) first_dat = n;
        tick();
      end
      check("inhibit_len", 32'(n), INH);
      check("start_bit_cycle", 32'(first_dat), INH);
    end else begin
      tx_valid = keep_valid;
      tx_data  = after_data;
      guard = 0;
      while (ps2_clk_oe && guard < INH + 20) begin tick(); guard++; end
    end
    check("start_bit_held", 32'(ps2_dat_oe), 1);
    wait_cyc($urandom_range(5, 100));
    for (int i = 0; i < 11; i++) begin
      dev_clk = 1'b0;
      wait_cyc(half);
      if (i < 10) cap[i] = ps2_dat_in;
      dev_clk = 1'b1;
      wait_cyc(half / 2);
      if (i == 9 && give_ack) dev_dat = 1'b0;
      wait_cyc(half - half / 2);
    end
    if (give_ack) begin
      check("no_done_while_ack_low", 32'(done_cnt - d0), 0);
      rel_cyc = cyc;
      dev_dat = 1'b1;
    end
    guard = 0;
    while (done_cnt == d0 && guard < BT + 50) begin tick(); guard++; end
    wait_cyc(5);
    check("frame_bits", 32'(cap), 32'(exp_bits));
    check("parity_bit", 32'(cap[8]), 32'(exp_par));
    check("done_pulses", 32'(done_cnt - d0), 1);
    check("ack", 32'(ack_at_done), 32'(give_ack));
    check("no_error", 32'(err_cnt - e0), 0);
    if (give_ack) check("done_after_release", 32'(done_cyc > rel_cyc), 1);
    if (!keep_valid) check("ready_after", 32'(tx_ready), 1);
    $display("frame data=%02h ack=%0d captured=%03h expected=%03h ack_out=%0d",
             d, give_ack, cap, exp_bits, ack_at_done);
  endtask

  task automatic send(input logic [7:0] d, input bit give_ack);
    tx_data  = d;
    tx_valid = 1'b1;
    serve(d, give_ack, 1'b1, $urandom_range(20, 60), 1'b0, 8'($urandom));
  endtask

  // Start a request and return once the host has released the clock.
  task automatic start_and_release(input logic [7:0] d);
    int guard;
    tx_data  = d;
    tx_valid = 1'b1;
    guard = 0;
    while (!ps2_clk_oe && guard < 20) begin tick(); guard++; end
    tx_valid = 1'b0;
    guard = 0;
    while (ps2_clk_oe && guard < INH + 20) begin tick(); guard++; end
    check("released", 32'(ps2_clk_oe), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, e0, r0, h, guard;
    logic [7:0] d1, d2;
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    wait_cyc(3);
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_clk_oe", 32'(ps2_clk_oe), 0);
    check("rst_dat_oe", 32'(ps2_dat_oe), 0);
    check("rst_done", 32'(tx_done), 0);
    check("rst_ack", 32'(tx_ack), 0);
    check("rst_error", 32'(tx_error), 0);
    reset_n = 1'b1;
    wait_cyc(50);
    check("idle_no_pulses", 32'(done_cnt + err_cnt), 0);
    check("idle_ready", 32'(tx_ready), 1);
    $display("reset idle ready=%0d clk_oe=%0d dat_oe=%0d", tx_ready, ps2_clk_oe, ps2_dat_oe);

    // Directed commands, then random frames.
    send(8'hED, 1'b1);
    send(8'hF4, 1'b0);
    send(8'hFF, 1'b1);
    for (int i = 0; i < 6; i++) send(8'($urandom), 1'($urandom));

    // No device: timeout from the first-edge wait.
    d0 = done_cnt;
    e0 = err_cnt;
    start_and_release(8'hF4);
    n = 0;
    while (!tx_error && n < FET + 50) begin tick(); n++; end
    check("first_edge_timeout", 32'(n), FET);
    check("abort_clk_oe", 32'(ps2_clk_oe), 0);
    check("abort_dat_oe", 32'(ps2_dat_oe), 0);
    tick();
    check("abort_ready", 32'(tx_ready), 1);
    check("abort_no_done", 32'(done_cnt - d0), 0);
    $display("no-device abort after %0d cycles", n);

    // Device stops after 4 falling edges.
    wait_cyc(5);
    e0 = err_cnt;
    h = 30;
    start_and_release(8'($urandom));
    wait_cyc(10);
    for (int i = 0; i < 3; i++) begin
      dev_clk = 1'b0; wait_cyc(h);
      dev_clk = 1'b1; wait_cyc(h);
    end
    dev_clk = 1'b0;
    n = 0;
    while (!tx_error && n < BT + 50) begin
      tick();
      n++;
      if (n == h) dev_clk = 1'b1;
    end
    dev_clk = 1'b1;
    // Pin-to-edge latency is 3 cycles.
    check("bit_timeout", 32'(n), BT + 3);
    check("bit_abort_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    tick();
    check("bit_abort_ready", 32'(tx_ready), 1);
    check("bit_abort_errs", 32'(err_cnt - e0), 1);
    $display("stalled device abort %0d cycles after 4th fall", n);

    // Reset in the middle of the data bits.
    wait_cyc(5);
    d0 = done_cnt;
    e0 = err_cnt;
    start_and_release(8'h00);
    wait_cyc(10);
    for (int i = 0; i < 5; i++) begin
      dev_clk = 1'b0; wait_cyc(h);
      if (i < 4) begin dev_clk = 1'b1; wait_cyc(h); end
    end
    check("pre_reset_dat_oe", 32'(ps2_dat_oe), 1);
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    dev_clk = 1'b1;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(20);
    check("rst_mid_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 0);
    check("rst_mid_ready", 32'(tx_ready), 1);
    $display("mid-frame reset: lines released, no pulses");

    // tx_valid held across a frame: one frame per accept.
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    r0 = oe_rises;
    tx_data  = d1;
    tx_valid = 1'b1;
    serve(d1, 1'b1, 1'b1, 25, 1'b1, d2);
    guard = 0;
    while (oe_rises < r0 + 2 && guard < 10) begin tick(); guard++; end
    check("held_frames", 32'(oe_rises - r0), 2);
    check("held_gap", 32'(oe_rise_cyc - ready_rise_cyc), 1);
    serve(d2, 1'b0, 1'b0, 25, 1'b0, 8'h00);
    $display("held valid: frames %02h then %02h", d1, d2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
